// File: rtl/sphere_contact_collector.sv
`default_nettype none
// ============================================================================
//  Module   : sphere_contact_collector
//  Purpose  : Captures one contact record per rising edge of the collider
//             done strobe when ret is non-zero, queues it in a show-ahead
//             FIFO, and drains it over a valid/ready interface. It also
//             reports occupancy and a sticky overflow flag so the pair
//             scheduler can throttle fetches.
//  Ports    : clk, rst (async, active-low)
//             done, ret, cx/cy/cz, normalx/y/z, depth   - collider result
//             flush                                     - sync clear
//             out_valid/out_ready, out_cx..out_depth    - head record
//             count, full, empty, overflow              - status
//  Options  : CONTACT_STATS_EN adds the pairs_tested, contacts_found and
//             contacts_dropped saturating counters.
//  Revision : 1.0 - initial release
// ============================================================================
module sphere_contact_collector #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          done,
    input  logic [DW-1:0] ret,
    input  logic [DW-1:0] cx,
    input  logic [DW-1:0] cy,
    input  logic [DW-1:0] cz,
    input  logic [DW-1:0] normalx,
    input  logic [DW-1:0] normaly,
    input  logic [DW-1:0] normalz,
    input  logic [DW-1:0] depth,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_cx,
    output logic [DW-1:0] out_cy,
    output logic [DW-1:0] out_cz,
    output logic [DW-1:0] out_nx,
    output logic [DW-1:0] out_ny,
    output logic [DW-1:0] out_nz,
    output logic [DW-1:0] out_depth,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow
`ifdef CONTACT_STATS_EN
    ,
    output logic [31:0]   pairs_tested,
    output logic [31:0]   contacts_found,
    output logic [15:0]   contacts_dropped
`endif
);

    localparam int         c_REC_W  = 7 * DW;
    localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

    logic [c_REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;
    logic               r_done_q;

    logic               w_event;
    logic               w_push_req;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [AW:0]        w_count_nxt;
    logic [c_REC_W-1:0] w_head;

    assign w_event    = done & ~r_done_q;
    assign w_push_req = w_event & (ret != '0);
    assign w_pop      = ~r_empty & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push     = w_push_req & (~r_full | w_pop);
    assign w_drop     = w_push_req & r_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_q   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_done_q <= done;
            if (flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_full     <= 1'b0;
                r_empty    <= 1'b1;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_drop) r_overflow <= 1'b1;
                r_count <= w_count_nxt;
                r_full  <= (w_count_nxt == c_FULL_CNT);
                r_empty <= (w_count_nxt == '0);
            end
        end
    end

    // Storage is intentionally not reset; the empty flag masks stale data.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= {cx, cy, cz, normalx, normaly, normalz, depth};
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = ~r_empty;
    // Data forced to zero while empty so reset shows all-zero outputs at once.
    assign out_cx    = r_empty ? '0 : w_head[6*DW +: DW];
    assign out_cy    = r_empty ? '0 : w_head[5*DW +: DW];
    assign out_cz    = r_empty ? '0 : w_head[4*DW +: DW];
    assign out_nx    = r_empty ? '0 : w_head[3*DW +: DW];
    assign out_ny    = r_empty ? '0 : w_head[2*DW +: DW];
    assign out_nz    = r_empty ? '0 : w_head[1*DW +: DW];
    assign out_depth = r_empty ? '0 : w_head[0 +: DW];
    assign count     = r_count;
    assign full      = r_full;
    assign empty     = r_empty;
    assign overflow  = r_overflow;

`ifdef CONTACT_STATS_EN
    logic [31:0] r_pairs;
    logic [31:0] r_found;
    logic [15:0] r_dropped;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pairs   <= '0;
            r_found   <= '0;
            r_dropped <= '0;
        end else if (flush) begin
            r_pairs   <= '0;
            r_found   <= '0;
            r_dropped <= '0;
        end else begin
            if (w_event && (r_pairs != '1))    r_pairs   <= r_pairs + 1'b1;
            if (w_push_req && (r_found != '1)) r_found   <= r_found + 1'b1;
            if (w_drop && (r_dropped != '1))   r_dropped <= r_dropped + 1'b1;
        end
    end

    assign pairs_tested     = r_pairs;
    assign contacts_found   = r_found;
    assign contacts_dropped = r_dropped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sphere_contact_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sphere_contact_collector
//  Purpose  : Scoreboard bench for sphere_contact_collector. Stimulus pushes
//             expected records into a queue; a monitor pops and compares on
//             every accepted output handshake. Status flags are checked
//             directly at chosen points.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sphere_contact_collector;

    typedef struct packed {
        logic [31:0] cx, cy, cz, nx, ny, nz, depth;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done = 1'b0;
    logic [31:0] ret = '0;
    logic [31:0] cx = '0, cy = '0, cz = '0;
    logic [31:0] normalx = '0, normaly = '0, normalz = '0, depth = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_cx, out_cy, out_cz, out_nx, out_ny, out_nz, out_depth;
    logic [3:0]  count;
    logic        full, empty, overflow;
`ifdef CONTACT_STATS_EN
    logic [31:0] pairs_tested, contacts_found;
    logic [15:0] contacts_dropped;
    int          exp_pairs = 0, exp_found = 0, exp_dropped = 0;
`endif

    rec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sphere_contact_collector #(.DEPTH(8), .AW(3), .DW(32)) dut (
        .clk(clk), .rst(rst), .done(done), .ret(ret),
        .cx(cx), .cy(cy), .cz(cz),
        .normalx(normalx), .normaly(normaly), .normalz(normalz),
        .depth(depth), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cx(out_cx), .out_cy(out_cy), .out_cz(out_cz),
        .out_nx(out_nx), .out_ny(out_ny), .out_nz(out_nz),
        .out_depth(out_depth),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
`ifdef CONTACT_STATS_EN
        ,
        .pairs_tested(pairs_tested), .contacts_found(contacts_found),
        .contacts_dropped(contacts_dropped)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head record must match the oldest expected one.
    initial begin
        rec_t e;
        rec_t a;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                a = '{out_cx, out_cy, out_cz, out_nx, out_ny, out_nz, out_depth};
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_record: got cx %h expected no record", a.cx);
                end else begin
                    e = sb.pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL record: got cx %h depth %h expected cx %h depth %h",
                                 a.cx, a.depth, e.cx, e.depth);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rec_t mk(input int i);
        rec_t r;
        r.cx    = 32'h4100_0000 + i;
        r.cy    = 32'h4200_0000 + i;
        r.cz    = 32'h4300_0000 + i;
        r.nx    = 32'h3F00_0000 + i;
        r.ny    = 32'hBF00_0000 + i;
        r.nz    = 32'h3E00_0000 + i;
        r.depth = 32'h3C00_0000 + i;
        return r;
    endfunction

    task automatic drive_rec(input rec_t r);
        cx = r.cx; cy = r.cy; cz = r.cz;
        normalx = r.nx; normaly = r.ny; normalz = r.nz; depth = r.depth;
    endtask

    // kind: 0 = not stored (ret==0), 1 = stored, 2 = dropped (full)
    task automatic pulse_done(input logic [31:0] r, input rec_t d, input int kind);
        done = 1'b1;
        ret  = r;
        drive_rec(d);
        if (kind == 1) sb.push_back(d);
`ifdef CONTACT_STATS_EN
        exp_pairs++;
        if (r != 0) exp_found++;
        if (kind == 2) exp_dropped++;
`endif
        tick();
        done = 1'b0;
        ret  = '0;
        tick();
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (empty) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b0;
        check(name, {31'd0, ok}, 32'd1);
    endtask

`ifdef CONTACT_STATS_EN
    task automatic check_stats(input string name);
        check({name, "_pairs"},   pairs_tested,           exp_pairs);
        check({name, "_found"},   contacts_found,         exp_found);
        check({name, "_dropped"}, {16'd0, contacts_dropped}, exp_dropped);
    endtask
`endif

    initial begin
        rec_t r;
        // Reset
        #12;
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_cx", out_cx, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // 1: single contact, one-cycle latency
        r = mk(0);
        r.cx = 32'hBEFC475E;
        r.depth = 32'h3C740000;
        done = 1'b1; ret = 32'd1; drive_rec(r); sb.push_back(r);
`ifdef CONTACT_STATS_EN
        exp_pairs++; exp_found++;
`endif
        check("t1_pre_valid", {31'd0, out_valid}, 32'd0);
        tick();
        done = 1'b0; ret = '0;
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_count", {28'd0, count}, 32'd1);
        check("t1_cx", out_cx, 32'hBEFC475E);
        check("t1_depth", out_depth, 32'h3C740000);
        drain("t1_drain");

        // 2: held done yields a single capture
        done = 1'b1; ret = 32'd1; r = mk(1); drive_rec(r); sb.push_back(r);
`ifdef CONTACT_STATS_EN
        exp_pairs++; exp_found++;
`endif
        repeat (10) tick();
        done = 1'b0; ret = '0;
        tick();
        check("t2_count", {28'd0, count}, 32'd1);
`ifdef CONTACT_STATS_EN
        check_stats("t2");
`endif
        drain("t2_drain");

        // 3: ret==0 is not stored
        pulse_done(32'd0, mk(2), 0);
        check("t3_count", {28'd0, count}, 32'd0);
        check("t3_valid", {31'd0, out_valid}, 32'd0);
`ifdef CONTACT_STATS_EN
        check_stats("t3");
`endif

        // 4: fill, overflow on the 9th, drain in order
        for (int i = 0; i < 8; i++) pulse_done(32'd1, mk(10 + i), 1);
        check("t4_full", {31'd0, full}, 32'd1);
        check("t4_count8", {28'd0, count}, 32'd8);
        check("t4_ovf_pre", {31'd0, overflow}, 32'd0);
        pulse_done(32'h8000_0000, mk(99), 2);
        check("t4_overflow", {31'd0, overflow}, 32'd1);
        check("t4_count_after", {28'd0, count}, 32'd8);
`ifdef CONTACT_STATS_EN
        check_stats("t4");
`endif
        drain("t4_drain");
        check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

        // 6a: flush with 3 entries and overflow set
        for (int i = 0; i < 3; i++) pulse_done(32'd5, mk(20 + i), 1);
        check("t6_count3", {28'd0, count}, 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
`ifdef CONTACT_STATS_EN
        exp_pairs = 0; exp_found = 0; exp_dropped = 0;
        check_stats("t6_flush");
`endif
        check("t6_count0", {28'd0, count}, 32'd0);
        check("t6_empty", {31'd0, empty}, 32'd1);
        check("t6_ovf", {31'd0, overflow}, 32'd0);

        // 5: full + simultaneous push/pop, pointers wrap past index 7
        for (int i = 0; i < 8; i++) pulse_done(32'd1, mk(30 + i), 1);
        check("t5_full", {31'd0, full}, 32'd1);
        r = mk(50);
        done = 1'b1; ret = 32'd7; drive_rec(r); sb.push_back(r);
        out_ready = 1'b1;
`ifdef CONTACT_STATS_EN
        exp_pairs++; exp_found++;
`endif
        tick();
        done = 1'b0; ret = '0; out_ready = 1'b0;
        check("t5_count", {28'd0, count}, 32'd8);
        check("t5_ovf", {31'd0, overflow}, 32'd0);
        check("t5_head", out_cx, 32'h4100_001F);
        drain("t5_drain");
`ifdef CONTACT_STATS_EN
        check_stats("t5");
`endif

        // 6b: asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) pulse_done(32'd1, mk(60 + i), 1);
        pulse_done(32'd1, mk(70), 1);
        out_ready = 1'b1;
        tick();
        #1;
        rst = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_count", {28'd0, count}, 32'd0);
        check("t6_rst_empty", {31'd0, empty}, 32'd1);
        check("t6_rst_cx", out_cx, 32'd0);
        check("t6_rst_depth", out_depth, 32'd0);
`ifdef CONTACT_STATS_EN
        exp_pairs = 0; exp_found = 0; exp_dropped = 0;
        check_stats("t6_rst");
`endif
        tick();
        tick();
        rst = 1'b1;
        tick();
        pulse_done(32'd3, mk(80), 1);
        check("post_rst_count", {28'd0, count}, 32'd1);
        drain("post_rst_drain");

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
